// File: rtl/qr_pkg.sv
// Shared pixel types and helpers for the QR front-end luma path.
package qr_pkg;

  localparam int PIX_W    = 10;
  localparam int HC_W_DEF = 11;
  localparam int VC_W_DEF = 10;

  typedef logic [PIX_W-1:0] pix_t;

  // Saturate a signed 12-bit value into the unsigned 10-bit pixel range.
  function automatic pix_t clamp10(input logic signed [11:0] v);
    pix_t r;
    if (v < 12'sd0) begin
      r = 10'd0;
    end else if (v > 12'sd1023) begin
      r = 10'd1023;
    end else begin
      r = v[9:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/luma_binarizer_pipe_delay.sv
// Reset-clearable shift register used to re-time side-band data by a fixed depth.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps_r [DEPTH];

  // Shift chain; reset clears every tap so no stale valid survives.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps_r[i] <= '0;
      end
    end else begin
      taps_r[0] <= data;
      for (int i = 1; i < DEPTH; i++) begin
        taps_r[i] <= taps_r[i-1];
      end
    end
  end

  assign q = taps_r[DEPTH-1];

endmodule

// File: rtl/luma_binarizer.sv
// Binarizes converter luma against a fixed or previous-window-mean threshold and
// re-times the pixel coordinates to match the 1-bit mask.
module luma_binarizer
  import qr_pkg::*;
#(
  parameter int CONV_LATENCY = 3,
  parameter int HC_W         = 11,
  parameter int VC_W         = 10,
  parameter int WIN_H_LOG2   = 10,
  parameter int WIN_V_LOG2   = 9,
  parameter int INIT_THRESH  = 512
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [9:0]      y_in,
  input  logic [HC_W-1:0] hcount_in,
  input  logic [VC_W-1:0] vcount_in,
  input  logic            valid_in,
  input  logic            adaptive_in,
  input  logic [9:0]      fixed_thresh_in,
  input  logic [10:0]     offset_in,
  output logic            bit_out,
  output logic [HC_W-1:0] hcount_out,
  output logic [VC_W-1:0] vcount_out,
  output logic            valid_out,
  output logic [9:0]      thresh_out
);

  localparam int ACC_W = PIX_W + WIN_H_LOG2 + WIN_V_LOG2;
  localparam int SHIFT = WIN_H_LOG2 + WIN_V_LOG2;
  localparam int D_W   = 1 + VC_W + HC_W;
  localparam pix_t            INIT_T = pix_t'(INIT_THRESH);
  localparam logic [HC_W-1:0] H_LAST = HC_W'(2**WIN_H_LOG2 - 1);
  localparam logic [VC_W-1:0] V_LAST = VC_W'(2**WIN_V_LOG2 - 1);

  logic [D_W-1:0]    d_bus_s;
  logic              d_valid_s;
  logic [VC_W-1:0]   d_vcount_s;
  logic [HC_W-1:0]   d_hcount_s;
  logic              in_win_s;
  logic              win_end_s;
  logic              wrap_s;
  logic [ACC_W-1:0]  acc_sum_s;
  pix_t              mean_s;
  logic signed [11:0] mean_off_s;
  pix_t              thresh_sel_s;

  logic [ACC_W-1:0]  acc_r;
  pix_t              mean_thresh_r;
  logic [VC_W-1:0]   prev_vcount_r;

  pipe_delay #(
    .WIDTH(D_W),
    .DEPTH(CONV_LATENCY)
  ) u_align (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .data     ({valid_in, vcount_in, hcount_in}),
    .q        (d_bus_s)
  );

  assign {d_valid_s, d_vcount_s, d_hcount_s} = d_bus_s;

  // Window membership, window end and frame-wrap detection on the re-timed pixel.
  always_comb begin
    in_win_s  = d_valid_s && ((d_hcount_s >> WIN_H_LOG2) == '0) &&
                ((d_vcount_s >> WIN_V_LOG2) == '0);
    win_end_s = d_valid_s && (d_hcount_s == H_LAST) && (d_vcount_s == V_LAST);
    wrap_s    = d_valid_s && (d_vcount_s < prev_vcount_r) && !win_end_s;
    acc_sum_s = acc_r + ACC_W'(y_in);
    mean_s    = pix_t'(acc_sum_s >> SHIFT);
    mean_off_s = signed'({2'b00, mean_s}) + signed'({offset_in[10], offset_in});
    thresh_sel_s = adaptive_in ? mean_thresh_r : fixed_thresh_in;
  end

  // Window statistics; the window-end pixel is included in the sum before the divide.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      acc_r         <= '0;
      mean_thresh_r <= INIT_T;
      prev_vcount_r <= '0;
    end else begin
      if (win_end_s) begin
        acc_r         <= '0;
        mean_thresh_r <= clamp10(mean_off_s);
      end else if (wrap_s) begin
        // Wrapped frame: drop the partial sum but keep the wrap pixel itself.
        acc_r <= in_win_s ? ACC_W'(y_in) : '0;
      end else if (in_win_s) begin
        acc_r <= acc_sum_s;
      end else begin
        acc_r <= acc_r;
      end
      if (d_valid_s) begin
        prev_vcount_r <= d_vcount_s;
      end else begin
        prev_vcount_r <= prev_vcount_r;
      end
    end
  end

  // Output register stage.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      bit_out    <= 1'b0;
      valid_out  <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
      thresh_out <= INIT_T;
    end else begin
      bit_out    <= d_valid_s && (y_in > thresh_sel_s);
      valid_out  <= d_valid_s;
      hcount_out <= d_hcount_s;
      vcount_out <= d_vcount_s;
      thresh_out <= thresh_sel_s;
    end
  end

endmodule

// File: tb/tb_luma_binarizer.sv
// Directed bench for luma_binarizer using a reduced 8x4 statistics window.
module tb_luma_binarizer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [9:0]  y_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        valid_in;
  logic        adaptive_in;
  logic [9:0]  fixed_thresh_in;
  logic [10:0] offset_in;
  logic        bit_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        valid_out;
  logic [9:0]  thresh_out;

  logic [9:0]  ysh [3];
  logic [9:0]  obs_thr [32];
  logic        obs_bit [32];
  int          n_pass  = 0;
  int          n_total = 0;

  luma_binarizer #(
    .CONV_LATENCY(3), .HC_W(11), .VC_W(10),
    .WIN_H_LOG2(3), .WIN_V_LOG2(2), .INIT_THRESH(512)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .y_in            (y_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .valid_in        (valid_in),
    .adaptive_in     (adaptive_in),
    .fixed_thresh_in (fixed_thresh_in),
    .offset_in       (offset_in),
    .bit_out         (bit_out),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .valid_out       (valid_out),
    .thresh_out      (thresh_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One pixel clock; y_in lags the coordinates by three cycles like the converter.
  task automatic px(input int h, input int v, input logic val, input int y);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    valid_in  = val;
    y_in      = ysh[2];
    ysh[2]    = ysh[1];
    ysh[1]    = ysh[0];
    ysh[0]    = 10'(y);
    @(posedge clk_in);
    #1;
  endtask

  task automatic frame(input int y, input int lines, input logic gaps);
    for (int v = 0; v < lines; v++) begin
      for (int h = 0; h < 8; h++) begin
        px(h, v, 1'b1, y);
        obs_thr[v*8+h] = thresh_out;
        obs_bit[v*8+h] = bit_out;
        if (gaps) px(h, v, 1'b0, 1023);
      end
    end
  endtask

  task automatic flush();
    repeat (4) px(0, 0, 1'b0, 0);
  endtask

  initial begin
    ysh[0] = 10'd0; ysh[1] = 10'd0; ysh[2] = 10'd0;
    rst_n_in = 1'b0; adaptive_in = 1'b0; fixed_thresh_in = 10'd300; offset_in = 11'd0;
    y_in = 10'd0; hcount_in = 11'd0; vcount_in = 10'd0; valid_in = 1'b0;

    // Reset
    repeat (5) px(0, 0, 1'b0, 0);
    check("rst_bit", 32'(bit_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_hcount", 32'(hcount_out), 32'd0);
    check("rst_vcount", 32'(vcount_out), 32'd0);
    check("rst_thresh", 32'(thresh_out), 32'd512);
    rst_n_in = 1'b1;

    // Fixed threshold, latency 4
    px(20, 50, 1'b1, 301);
    px(21, 50, 1'b1, 300);
    px(0, 0, 1'b0, 0);
    check("lat_early_valid", 32'(valid_out), 32'd0);
    px(0, 0, 1'b0, 0);
    check("fix_valid", 32'(valid_out), 32'd1);
    check("fix_bit_301", 32'(bit_out), 32'd1);
    check("fix_hcount", 32'(hcount_out), 32'd20);
    check("fix_vcount", 32'(vcount_out), 32'd50);
    check("fix_thresh", 32'(thresh_out), 32'd300);
    px(0, 0, 1'b0, 0);
    check("fix_bit_300", 32'(bit_out), 32'd0);
    check("fix_hcount2", 32'(hcount_out), 32'd21);
    px(0, 0, 1'b0, 0);
    check("fix_valid_end", 32'(valid_out), 32'd0);

    // Adaptive: mean 200 + 20, effective from the pixel after window end
    adaptive_in = 1'b1; offset_in = 11'd20;
    frame(200, 4, 1'b0);
    check("ad_bit_under_init", 32'(obs_bit[5]), 32'd0);
    frame(221, 4, 1'b0);
    check("ad_thr_at_end", 32'(obs_thr[2]), 32'd512);
    check("ad_thr_next", 32'(obs_thr[3]), 32'd220);
    check("ad_bit_221", 32'(obs_bit[3]), 32'd1);
    check("ad_bit_221b", 32'(obs_bit[10]), 32'd1);
    flush();
    check("ad_thr_241", 32'(thresh_out), 32'd241);

    // Clamp high and low
    offset_in = 11'd100;
    frame(1000, 4, 1'b0);
    flush();
    check("clamp_hi", 32'(thresh_out), 32'd1023);
    offset_in = 11'h7CE;
    frame(10, 4, 1'b0);
    check("clamp_bit_10", 32'(obs_bit[3]), 32'd0);
    flush();
    check("clamp_lo", 32'(thresh_out), 32'd0);

    // Restart guard: partial frame then wrap straight into a full window
    offset_in = 11'd0;
    frame(900, 2, 1'b0);
    check("guard_bit_900", 32'(obs_bit[5]), 32'd1);
    frame(100, 4, 1'b0);
    check("guard_hold", 32'(obs_thr[3]), 32'd0);
    flush();
    check("guard_mean", 32'(thresh_out), 32'd100);

    // Mid-frame reset, then a gapped full frame
    frame(900, 2, 1'b0);
    rst_n_in = 1'b0;
    px(0, 0, 1'b0, 0);
    px(0, 0, 1'b0, 0);
    check("mrst_thresh", 32'(thresh_out), 32'd512);
    check("mrst_valid", 32'(valid_out), 32'd0);
    rst_n_in = 1'b1;
    frame(64, 4, 1'b1);
    flush();
    check("gap_mean", 32'(thresh_out), 32'd64);

    // Mode switch takes effect on the next pixel
    adaptive_in = 1'b0; fixed_thresh_in = 10'd63;
    px(0, 0, 1'b0, 0);
    check("mode_switch", 32'(thresh_out), 32'd63);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
